// File: rtl/mc_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute sequencing, datapath strobes, retire counter.
// Optional build macro ILLEGAL_TRAP_EN: an illegal opcode halts the core instead of acting as a NOP.
module mc_controller #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic [7:0]       instr_func,
    input  logic             zero,
    input  logic             mem_ready,
    output logic [1:0]       alu_op,
    output logic [7:0]       func,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    localparam logic [3:0] OpRtype = 4'd0;
    localparam logic [3:0] OpAddi  = 4'd1;
    localparam logic [3:0] OpSubi  = 4'd2;
    localparam logic [3:0] OpLw    = 4'd3;
    localparam logic [3:0] OpSw    = 4'd4;
    localparam logic [3:0] OpBeq   = 4'd5;
    localparam logic [3:0] OpJmp   = 4'd6;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExec, StMemRd, StMemWb, StMemWr, StAluWb, StBranch, StJump, StHalt
    } state_e;

    state_e     state_q, state_d;
    logic       retire, illegal_d, jump_pc_write_q;
    logic [1:0] alu_op_d, alu_src_b_d, pc_source_d;
    logic [7:0] func_d;
    logic       pc_write_cond_d, mem_read_d, mem_write_d, iord_d, reg_write_d;
    logic       mem_to_reg_d, alu_src_a_d, jump_pc_write_d;
    logic       zero_unused;

    // zero is consumed by the datapath together with pc_write_cond
    assign zero_unused = zero;

    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            StFetch:  if (mem_ready) state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpRtype, OpAddi, OpSubi, OpLw, OpSw: state_d = StExec;
                    OpBeq:   state_d = StBranch;
                    OpJmp:   state_d = StJump;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_d = StHalt;
`else
                        state_d   = StFetch;
                        illegal_d = 1'b1;
`endif
                    end
                endcase
            end
            StExec: begin
                if (opcode == OpLw)      state_d = StMemRd;
                else if (opcode == OpSw) state_d = StMemWr;
                else                     state_d = StAluWb;
            end
            StMemRd:  if (mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StMemWb, StAluWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StHalt:   state_d = StHalt;
            default:  state_d = StFetch;
        endcase
        if (state_d == StHalt) illegal_d = 1'b1;
    end

    // Outputs are decoded from the next state so they are registered alongside it
    always_comb begin
        alu_op_d        = 2'b00;
        func_d          = 8'h00;
        pc_write_cond_d = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        iord_d          = 1'b0;
        reg_write_d     = 1'b0;
        mem_to_reg_d    = 1'b0;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        pc_source_d     = 2'b00;
        jump_pc_write_d = 1'b0;
        unique case (state_d)
            StFetch: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
            end
            StDecode: alu_src_b_d = 2'b10;
            StExec: begin
                alu_src_a_d = 1'b1;
                if (opcode == OpRtype) begin
                    alu_op_d = 2'b11;
                    func_d   = instr_func;
                end else begin
                    alu_src_b_d = 2'b10;
                    if (opcode == OpSubi) alu_op_d = 2'b01;
                end
            end
            StMemRd: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
            end
            StMemWr: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
            end
            StMemWb: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            StAluWb: reg_write_d = 1'b1;
            StBranch: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
            end
            StJump: begin
                jump_pc_write_d = 1'b1;
                pc_source_d     = 2'b10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StFetch;
            instr_count     <= '0;
            illegal         <= 1'b0;
            alu_op          <= 2'b00;
            func            <= 8'h00;
            pc_write_cond   <= 1'b0;
            mem_read        <= 1'b1;
            mem_write       <= 1'b0;
            iord            <= 1'b0;
            reg_write       <= 1'b0;
            mem_to_reg      <= 1'b0;
            alu_src_a       <= 1'b0;
            alu_src_b       <= 2'b01;
            pc_source       <= 2'b00;
            jump_pc_write_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            illegal         <= illegal_d;
            alu_op          <= alu_op_d;
            func            <= func_d;
            pc_write_cond   <= pc_write_cond_d;
            mem_read        <= mem_read_d;
            mem_write       <= mem_write_d;
            iord            <= iord_d;
            reg_write       <= reg_write_d;
            mem_to_reg      <= mem_to_reg_d;
            alu_src_a       <= alu_src_a_d;
            alu_src_b       <= alu_src_b_d;
            pc_source       <= pc_source_d;
            jump_pc_write_q <= jump_pc_write_d;
            if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Fetch strobes follow the live handshake; reset suppresses them
    assign ir_write = (state_q == StFetch) && mem_ready && !rst;
    assign pc_write = jump_pc_write_q || ir_write;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: directed instruction sequences, per-cycle expected outputs.
module tb_mc_controller;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_ADD = 3, S_EXEC_SUB = 4;
    localparam int S_MEM_RD = 5, S_MEM_WR = 6, S_MEM_WB = 7, S_ALU_WB = 8, S_BRANCH = 9;
    localparam int S_JUMP = 10, S_HALT = 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [7:0] instr_func = 8'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [1:0] alu_op, alu_src_b, pc_source;
    logic [7:0] func;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
    logic       reg_write, mem_to_reg, alu_src_a, illegal;
    logic [3:0] instr_count;

    mc_controller #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_func(instr_func), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .func(func), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
        .instr_count(instr_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [27:0] exp_q[$];
    string       nm_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  cnt = 4'd0;

    // Output vector layout: pw pwc irw mrd mwr iord rw m2r sa | srcb pcsrc aluop | func | ill | count
    function automatic logic [27:0] ev(input int st, input logic [7:0] f, input logic mr,
                                       input logic ill, input logic [3:0] c);
        logic       pw, pwc, irw, mrd, mwr, io, rw, m2r, sa;
        logic [1:0] sb, ps, op;
        logic [7:0] fn;
        {pw, pwc, irw, mrd, mwr, io, rw, m2r, sa} = 9'b0;
        sb = 2'b00; ps = 2'b00; op = 2'b00; fn = 8'h00;
        case (st)
            S_FETCH:    begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            S_DECODE:   sb = 2'b10;
            S_EXEC_R:   begin sa = 1'b1; op = 2'b11; fn = f; end
            S_EXEC_ADD: begin sa = 1'b1; sb = 2'b10; end
            S_EXEC_SUB: begin sa = 1'b1; sb = 2'b10; op = 2'b01; end
            S_MEM_RD:   begin mrd = 1'b1; io = 1'b1; end
            S_MEM_WR:   begin mwr = 1'b1; io = 1'b1; end
            S_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
            S_ALU_WB:   rw = 1'b1;
            S_BRANCH:   begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; end
            S_JUMP:     begin pw = 1'b1; ps = 2'b10; end
            default:    ;
        endcase
        return {pw, pwc, irw, mrd, mwr, io, rw, m2r, sa, sb, ps, op, fn, ill, c};
    endfunction

    // Called at posedge+1: drive mem_ready, queue this cycle's expectation, advance one cycle
    task automatic step(input int st, input logic mr, input logic ill, input bit ret,
                        input string nm);
        mem_ready = mr;
        exp_q.push_back(ev(st, instr_func, mr & ~rst, ill, cnt));
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        if (ret) cnt = cnt + 4'd1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [27:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, pc_source, alu_op, func, illegal, instr_count};
            tests++;
            if (a !== e) begin
                fails++;
                $display("FAIL %s: got %07h expected %07h", n, a, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type, func 08
        opcode = 4'd0; instr_func = 8'h08;
        step(S_FETCH, 1, 0, 0, "r_fetch");
        step(S_DECODE, 1, 0, 0, "r_decode");
        step(S_EXEC_R, 1, 0, 0, "r_exec");
        step(S_ALU_WB, 1, 0, 1, "r_wb");

        // LW with three memory wait cycles
        opcode = 4'd3; instr_func = 8'hA5;
        step(S_FETCH, 1, 0, 0, "lw_fetch");
        step(S_DECODE, 1, 0, 0, "lw_decode");
        step(S_EXEC_ADD, 1, 0, 0, "lw_exec");
        for (int i = 0; i < 3; i++) step(S_MEM_RD, 0, 0, 0, "lw_memrd_wait");
        step(S_MEM_RD, 1, 0, 0, "lw_memrd_done");
        step(S_MEM_WB, 1, 0, 1, "lw_wb");

        // SW
        opcode = 4'd4;
        step(S_FETCH, 1, 0, 0, "sw_fetch");
        step(S_DECODE, 1, 0, 0, "sw_decode");
        step(S_EXEC_ADD, 1, 0, 0, "sw_exec");
        step(S_MEM_WR, 1, 0, 1, "sw_memwr");

        // SUBI
        opcode = 4'd2;
        step(S_FETCH, 1, 0, 0, "subi_fetch");
        step(S_DECODE, 1, 0, 0, "subi_decode");
        step(S_EXEC_SUB, 1, 0, 0, "subi_exec");
        step(S_ALU_WB, 1, 0, 1, "subi_wb");

        // ADDI with one fetch wait cycle
        opcode = 4'd1;
        step(S_FETCH, 0, 0, 0, "addi_fetch_wait");
        step(S_FETCH, 1, 0, 0, "addi_fetch");
        step(S_DECODE, 1, 0, 0, "addi_decode");
        step(S_EXEC_ADD, 1, 0, 0, "addi_exec");
        step(S_ALU_WB, 1, 0, 1, "addi_wb");

        // BEQ taken then not taken: controller outputs identical
        opcode = 4'd5;
        zero = 1'b1;
        step(S_FETCH, 1, 0, 0, "beq1_fetch");
        step(S_DECODE, 1, 0, 0, "beq1_decode");
        step(S_BRANCH, 1, 0, 1, "beq1_branch");
        zero = 1'b0;
        step(S_FETCH, 1, 0, 0, "beq0_fetch");
        step(S_DECODE, 1, 0, 0, "beq0_decode");
        step(S_BRANCH, 1, 0, 1, "beq0_branch");

        // Illegal opcode
        opcode = 4'hF;
        step(S_FETCH, 1, 0, 0, "ill_fetch");
        step(S_DECODE, 1, 0, 0, "ill_decode");
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) step(S_HALT, 1, 1, 0, "ill_halt");
        rst = 1'b1;
        step(S_HALT, 1, 1, 0, "ill_halt_rst");
        rst = 1'b0;
        cnt = 4'd0;
        step(S_FETCH, 0, 0, 0, "ill_after_rst");
`else
        step(S_FETCH, 0, 1, 0, "ill_nop_pulse");
        step(S_FETCH, 0, 0, 0, "ill_nop_clear");
`endif

        // Reset during a stalled SW
        opcode = 4'd4;
        step(S_FETCH, 1, 0, 0, "swr_fetch");
        step(S_DECODE, 1, 0, 0, "swr_decode");
        step(S_EXEC_ADD, 1, 0, 0, "swr_exec");
        step(S_MEM_WR, 0, 0, 0, "swr_memwr_wait");
        rst = 1'b1;
        step(S_MEM_WR, 0, 0, 0, "swr_memwr_rst");
        rst = 1'b0;
        cnt = 4'd0;
        step(S_FETCH, 0, 0, 0, "swr_after_rst");

        // 16 JMPs wrap the 4-bit counter back to zero
        opcode = 4'd6;
        for (int i = 0; i < 16; i++) begin
            step(S_FETCH, 1, 0, 0, "jmp_fetch");
            step(S_DECODE, 1, 0, 0, "jmp_decode");
            step(S_JUMP, 1, 0, 1, "jmp_jump");
        end
        cnt = 4'd0;
        step(S_FETCH, 0, 0, 0, "jmp_wrapped");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: CNT_W, 16, width of the retired-instruction counter.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 opcode  in  4  instruction-register bits [15:12].
REQ-005 instr_func  in  8  instruction-register bits [7:0].
REQ-006 zero  in  1  ALU zero flag for the current ALU result.
REQ-007 mem_ready  in  1  memory handshake: access completes in any cycle it is high.
REQ-008 alu_op  out  2  ALU operation class: 00 add, 01 sub, 11 func-decoded.
REQ-009 func  out  8  ALU function field.
REQ-010 Datapath strobes, 1 bit each: pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg, alu_src_a.
REQ-011 alu_src_b  out  2  B-operand select: 00 reg B, 01 constant 1, 10 sign-extended immediate.
REQ-012 pc_source  out  2  next-PC select: 00 ALU result, 01 ALUOut register, 10 jump target.
REQ-013 instr_count  out  CNT_W  retired-instruction count.
REQ-014 illegal  out  1  illegal-opcode indicator.

Function
REQ-015 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT, with registered state and Moore outputs.
REQ-016 Opcodes SHALL be: 0000 R-type, 0001 ADDI, 0010 SUBI, 0011 LW, 0100 SW, 0101 BEQ, 0110 JMP; all others are illegal.
REQ-017 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
REQ-018 FETCH SHALL assert ir_write and pc_write only in a cycle where mem_ready=1.
REQ-019 FETCH SHALL hold while mem_ready=0 and go to DECODE on mem_ready=1.
REQ-020 DECODE SHALL assert alu_src_a=0, alu_src_b=10, alu_op=00 (branch-target precompute) for exactly one cycle.
REQ-021 DECODE SHALL go to EXEC for R-type, ADDI, SUBI, LW and SW; to BRANCH for BEQ; to JUMP for JMP.
REQ-022 DECODE SHALL handle an illegal opcode per REQ-037/REQ-038.
REQ-023 EXEC SHALL assert alu_src_a=1.
REQ-024 EXEC SHALL set alu_op=11, func=instr_func and alu_src_b=00 for R-type.
REQ-025 EXEC SHALL set alu_src_b=10 and alu_op=00 for ADDI, LW and SW, and alu_op=01 for SUBI.
REQ-026 EXEC SHALL then go to MEM_RD for LW, MEM_WR for SW, and ALU_WB otherwise.
REQ-027 MEM_RD SHALL assert mem_read and iord=1, hold until mem_ready=1, then go to MEM_WB.
REQ-028 MEM_WR SHALL assert mem_write and iord=1, hold until mem_ready=1, then go to FETCH.
REQ-029 MEM_WB SHALL assert reg_write and mem_to_reg=1, then go to FETCH.
REQ-030 ALU_WB SHALL assert reg_write with mem_to_reg=0, then go to FETCH.
REQ-031 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=01, then go to FETCH; the datapath loads PC when pc_write_cond and zero are both 1.
REQ-032 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-033 Every output not named for the current state SHALL be 0; func SHALL be 0 outside EXEC.
REQ-034 instr_count SHALL increment by 1 on the cycle leaving MEM_WR, MEM_WB, ALU_WB, BRANCH or JUMP, and SHALL wrap from all-ones to 0.
REQ-035 Cycles per instruction with mem_ready always 1: R-type/ADDI/SUBI 4, LW 5, SW 4, BEQ 3, JMP 3; each wait cycle adds one.

Reset
REQ-036 With rst=1 at a rising edge, including mid-instruction or mid-memory-wait: state SHALL become FETCH, instr_count SHALL become 0, illegal SHALL become 0, and no strobe SHALL fire in that cycle; outputs SHALL then take FETCH values.

Configuration
REQ-037 With macro ILLEGAL_TRAP_EN defined, an illegal opcode in DECODE SHALL go to HALT; HALT asserts illegal=1 and all strobes 0, and is left only by rst.
REQ-038 Without ILLEGAL_TRAP_EN, an illegal opcode SHALL be a NOP: DECODE goes to FETCH, illegal pulses high for one cycle in that transition, and instr_count does not increment.

Verification
REQ-039 rst for 2 cycles, then mem_ready=1, opcode=0000, instr_func=8'h08 -> state sequence FETCH,DECODE,EXEC,ALU_WB; alu_op=11 and func=8'h08 in EXEC; instr_count=1.
REQ-040 LW (0011) with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held for 4 cycles; one reg_write with mem_to_reg=1; total 8 cycles.
REQ-041 BEQ (0101) with zero=1, then zero=0 -> pc_write_cond=1, pc_source=01, alu_op=01 in BRANCH both times; 3 cycles each; instr_count increases by 2.
REQ-042 Opcode 1111 -> with ILLEGAL_TRAP_EN, illegal stays 1 and strobes stay 0 for 20 cycles until rst; without it, a one-cycle illegal pulse, then FETCH.
REQ-043 rst asserted in MEM_WR while mem_ready=0 -> no mem_write on the following cycle, state FETCH, instr_count=0.
REQ-044 instr_count forced to near wrap (CNT_W=4, 16 JMPs) -> reads 0 after the 16th JMP.
